// File: rtl/bip_uart_pkg.sv
// Shared constants, register map and FSM encodings for the BIP UART peripheral.
package bip_uart_pkg;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int unsigned STAT_TX_BUSY   = 0;
    localparam int unsigned STAT_RX_VALID  = 1;
    localparam int unsigned STAT_OVERRUN   = 2;
    localparam int unsigned STAT_FRAME_ERR = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Last count of the half-bit wait used to reach the middle of the start bit.
    function automatic logic [DIV_W-1:0] half_bit_last(input logic [DIV_W-1:0] div);
        return DIV_W'((({1'b0, div} + (DIV_W+1)'(1)) >> 1) - (DIV_W+1)'(1));
    endfunction

endpackage

// File: rtl/bip_uart_periph_if.sv
// Link between the RX engine and the register block: divisor out, received byte and pulses back.
interface bip_uart_periph_if;
    import bip_uart_pkg::*;

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_done;
    logic              rx_ferr;
    logic [DIV_W-1:0]  div;

    modport master (output rx_byte, output rx_done, output rx_ferr, input div);
    modport slave  (input rx_byte, input rx_done, input rx_ferr, output div);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchroniser, mid-bit sampling FSM, registered byte with done/frame_err pulses.
module uart_rx_core
    import bip_uart_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    bip_uart_periph_if.master  link
);

    logic              sync1_q, sync2_q, prev_q;
    rx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              fall_c, boundary_c;
    logic [DIV_W-1:0]  last_c;

    assign link.rx_byte = byte_q;
    assign link.rx_done = done_q;
    assign link.rx_ferr = ferr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_c     = prev_q & ~sync2_q;
    assign last_c     = (state_q == RX_START) ? half_bit_last(div_q) : div_q;
    assign boundary_c = (cnt_q == last_c);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (fall_c) state_d = RX_START;
            // A line back high at mid start bit is treated as a glitch.
            RX_START: if (boundary_c) state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (boundary_c && (bit_q == 3'd7)) state_d = RX_STOP;
            RX_STOP:  if (boundary_c) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == RX_IDLE) begin
            cnt_d = '0;
            bit_d = '0;
            div_d = link.div;
        end else if (boundary_c) begin
            cnt_d = '0;
            div_d = link.div;
            case (state_q)
                RX_DATA: begin
                    shift_d = {sync2_q, shift_q[BYTE_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                end
                RX_STOP: begin
                    done_d = sync2_q;
                    ferr_d = ~sync2_q;
                    if (sync2_q) byte_d = shift_q;
                end
                default: ;
            endcase
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: rtl/bip_uart_periph.sv
// Memory-mapped 8N1 UART on the BIP peripheral bus: decode, registers, flags, TX engine, tri-state read.
module bip_uart_periph
    import bip_uart_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH  = 16,
    parameter int unsigned            ADDR_WIDTH  = 10,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 10'h000,
    parameter logic [DIV_W-1:0]       DEFAULT_DIV = 16'd433
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [ADDR_WIDTH-1:0]  i_addr_bus,
    input  logic                   i_cs_perif,
    input  logic                   i_w_r,
    inout  wire  [DATA_WIDTH-1:0]  io_data_bus,
    input  logic                   i_rx,
    output logic                   o_tx
);

    logic                  sel_c, rd_c, wr_c, tx_start_c, tx_busy_c, tx_boundary_c;
    logic [1:0]            offset_c;
    logic [DATA_WIDTH-1:0] wdata_c, rdata_c, status_c;

    logic [DIV_W-1:0]  baud_q, baud_d;
    logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;

    tx_state_e         tx_state_q, tx_state_d;
    logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [DIV_W-1:0]  tx_div_q, tx_div_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_q, tx_d;

    bip_uart_periph_if rx_link ();

    assign rx_link.div = baud_q;

    uart_rx_core u_rx (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_rx  (i_rx),
        .link  (rx_link)
    );

    assign sel_c      = i_cs_perif && (i_addr_bus[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
    assign rd_c       = sel_c && !i_w_r;
    assign wr_c       = sel_c && i_w_r;
    assign offset_c   = i_addr_bus[1:0];
    assign wdata_c    = io_data_bus;
    assign tx_busy_c  = (tx_state_q != TX_IDLE);
    assign tx_start_c = wr_c && (offset_c == REG_TXDATA) && !tx_busy_c;
    assign o_tx       = tx_q;

    always_comb begin
        status_c                 = '0;
        status_c[STAT_TX_BUSY]   = tx_busy_c;
        status_c[STAT_RX_VALID]  = rx_valid_q;
        status_c[STAT_OVERRUN]   = overrun_q;
        status_c[STAT_FRAME_ERR] = frame_err_q;
        case (offset_c)
            REG_RXDATA: rdata_c = DATA_WIDTH'(rx_byte_q);
            REG_STATUS: rdata_c = status_c;
            REG_BAUD:   rdata_c = DATA_WIDTH'(baud_q);
            default:    rdata_c = '0;
        endcase
    end

    assign io_data_bus = rd_c ? rdata_c : {DATA_WIDTH{1'bz}};

    // Flag updates: an RX event on the same edge as the clearing read wins.
    always_comb begin
        baud_d      = (wr_c && (offset_c == REG_BAUD)) ? DIV_W'(wdata_c) : baud_q;
        rx_byte_d   = rx_link.rx_done ? rx_link.rx_byte : rx_byte_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (rd_c && (offset_c == REG_RXDATA)) rx_valid_d = 1'b0;
        if (rd_c && (offset_c == REG_STATUS)) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_link.rx_done) begin
            rx_valid_d = 1'b1;
            if (rx_valid_q) overrun_d = 1'b1;
        end
        if (rx_link.rx_ferr) frame_err_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            baud_q      <= DEFAULT_DIV;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            baud_q      <= baud_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign tx_boundary_c = (tx_cnt_q == tx_div_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) tx_state_q <= TX_IDLE;
        else       tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (tx_start_c) tx_state_d = TX_START;
            TX_START: if (tx_boundary_c) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_boundary_c && (tx_bit_q == 3'd7)) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_boundary_c) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // Line level follows the state one clock later; divisor is re-latched at every bit boundary.
    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_q[0];
            default:  tx_d = 1'b1;
        endcase
        if (tx_state_q == TX_IDLE) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            tx_div_d = baud_q;
            if (tx_start_c) tx_shift_d = wdata_c[BYTE_W-1:0];
        end else if (tx_boundary_c) begin
            tx_cnt_d = '0;
            tx_div_d = baud_q;
            if (tx_state_q == TX_DATA) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 3'd1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_bip_uart_periph.sv
// Directed bench for bip_uart_periph with TX-bit and RX-byte scoreboards.
module tb_bip_uart_periph;
    import bip_uart_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;
    localparam logic [AW-1:0] BASE = 10'h000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          cs, w_r, rx, tx;
    logic [DW-1:0] drv;
    logic          drv_en;
    wire  [DW-1:0] data_bus;

    int checks = 0;
    int errors = 0;

    logic       tx_exp[$];
    logic [7:0] rx_q[$];
    logic       m_ovr, m_ferr;
    logic [7:0] m_byte;
    logic [DW-1:0] r;

    assign data_bus = drv_en ? drv : {DW{1'bz}};
    for (genvar g = 0; g < DW; g++) begin : g_pull
        pullup (data_bus[g]);
    end

    always #5 clk = ~clk;

    bip_uart_periph #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .DEFAULT_DIV(16'd433)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_addr_bus (addr),
        .i_cs_perif (cs),
        .i_w_r      (w_r),
        .io_data_bus(data_bus),
        .i_rx       (rx),
        .o_tx       (tx)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle starting just after an edge; read data sampled mid-cycle.
    task automatic bus_cycle(input logic c, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output logic [DW-1:0] q);
        cs = c; w_r = w; addr = a; drv = d; drv_en = w;
        #2;
        q = data_bus;
        @(posedge clk);
        #1;
        cs = 1'b0; w_r = 1'b0; drv_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] off, input logic [DW-1:0] d);
        logic [DW-1:0] q;
        bus_cycle(1'b1, 1'b1, BASE + AW'(off), d, q);
    endtask

    task automatic rd(input logic [1:0] off, output logic [DW-1:0] q);
        bus_cycle(1'b1, 1'b0, BASE + AW'(off), '0, q);
    endtask

    // Sends one byte, checks every o_tx level and tx_busy; a second write mid-frame must be ignored.
    task automatic run_tx(input logic [7:0] b);
        logic [9:0]    fr;
        logic [DW-1:0] q;
        logic          e;
        fr = {1'b1, b, 1'b0};
        for (int j = 0; j < 10; j++)
            for (int k = 0; k < 4; k++) tx_exp.push_back(fr[j]);
        wr(REG_TXDATA, {8'h00, b});
        for (int i = 0; i < 40; i++) begin
            if (i == 12) begin
                wr(REG_TXDATA, {8'h00, ~b});
            end else begin
                rd(REG_STATUS, q);
                chk("tx_busy", {15'd0, q[0]}, 16'd1);
            end
            checks++;
            assert (tx_exp.size() > 0) else begin
                errors++;
                $error("FAIL tx_queue: observed empty expected a bit");
            end
            if (tx_exp.size() > 0) begin
                e = tx_exp.pop_front();
                chk("tx_line", {15'd0, tx}, {15'd0, e});
            end
        end
    endtask

    // Drives an 8N1 frame at 4 clocks per bit and records the expected outcome.
    task automatic drive_rx(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (rx_q.size() > 0) m_ovr = 1'b1;
            rx_q.push_back(b);
        end else begin
            m_ferr = 1'b1;
        end
        rx = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (4) step();
        end
        rx = stop_ok;
        repeat (4) step();
        rx = 1'b1;
        repeat (6) step();
    endtask

    task automatic chk_status(input string tag);
        logic [DW-1:0] q;
        rd(REG_STATUS, q);
        chk(tag, q, {12'd0, m_ferr, m_ovr, rx_q.size() > 0, 1'b0});
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic chk_rxdata(input string tag);
        logic [DW-1:0] q;
        rd(REG_RXDATA, q);
        if (rx_q.size() > 0) m_byte = rx_q[$];
        rx_q.delete();
        chk(tag, q, {8'h00, m_byte});
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; w_r = 1'b0; addr = '0; drv = '0; drv_en = 1'b0; rx = 1'b1;
        m_ovr = 1'b0; m_ferr = 1'b0; m_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_tx", {15'd0, tx}, 16'd1);
        chk("reset_hiz", data_bus, 16'hFFFF);
        rd(REG_STATUS, r);  chk("reset_status", r, 16'h0000);
        rd(REG_BAUD, r);    chk("reset_baud", r, 16'd433);
        rd(REG_RXDATA, r);  chk("reset_rxdata", r, 16'h0000);

        wr(REG_BAUD, 16'd3);
        rd(REG_BAUD, r);    chk("baud_rw", r, 16'd3);
        rd(REG_TXDATA, r);  chk("txdata_read", r, 16'h0000);

        run_tx(8'h55);
        run_tx(8'hC3);
        rd(REG_STATUS, r);  chk("tx_done_status", r, 16'h0000);
        chk("tx_idle_line", {15'd0, tx}, 16'd1);

        drive_rx(8'hA3, 1'b1);
        chk_status("rx_status_valid");
        chk_rxdata("rx_data_a3");
        chk_status("rx_status_clear");

        drive_rx(8'h11, 1'b1);
        drive_rx(8'h22, 1'b1);
        chk_status("overrun_status");
        chk_rxdata("overrun_data");
        chk_status("overrun_clear");

        drive_rx(8'h5A, 1'b0);
        chk_status("frame_err_status");
        chk_status("frame_err_clear");
        chk_rxdata("frame_err_keep_byte");

        rx = 1'b0;
        step();
        rx = 1'b1;
        repeat (20) step();
        chk_status("glitch_status");
        drive_rx(8'h3C, 1'b1);
        chk_rxdata("after_glitch_data");

        wr(2'd0, 16'h0000);
        bus_cycle(1'b1, 1'b1, BASE + AW'(4 + 3), 16'h1234, r);
        bus_cycle(1'b0, 1'b1, BASE + AW'(REG_BAUD), 16'h4321, r);
        bus_cycle(1'b1, 1'b1, BASE + AW'(4), 16'h00FF, r);
        repeat (2) step();
        chk("decode_tx_idle", {15'd0, tx}, 16'd0);
        repeat (40) step();
        rd(REG_BAUD, r);    chk("decode_baud", r, 16'd3);
        rd(REG_STATUS, r);  chk("decode_status", r, 16'h0000);
        chk("decode_tx_line", {15'd0, tx}, 16'd1);
        bus_cycle(1'b1, 1'b0, BASE + AW'(4 + 3), '0, r);
        chk("decode_addr_hiz", r, 16'hFFFF);
        bus_cycle(1'b0, 1'b0, BASE + AW'(REG_BAUD), '0, r);
        chk("decode_cs_hiz", r, 16'hFFFF);

        wr(REG_TXDATA, 16'h0000);
        repeat (6) step();
        chk("midframe_tx_low", {15'd0, tx}, 16'd0);
        rst = 1'b1;
        step();
        chk("midframe_reset_tx", {15'd0, tx}, 16'd1);
        rst = 1'b0;
        rd(REG_STATUS, r);  chk("midframe_reset_status", r, 16'h0000);
        rd(REG_BAUD, r);    chk("midframe_reset_baud", r, 16'd433);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
